// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state encoding for the MEM-stage SRAM controller
package mem_pkg;

    // Byte address that lands on SRAM half-word pair 0.
    localparam int unsigned DEF_MEM_BASE = 1024;
    // SRAM address width, counted in half-words.
    localparam int unsigned DEF_SRAM_AW  = 18;
    // SRAM data bus width; a 32-bit word takes two accesses.
    localparam int unsigned SRAM_DW      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// rtl/mem_stage_sram_ctrl_if.sv - pipeline-side load/store request bus
interface mem_stage_sram_ctrl_if;

    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [31:0] ALU_result_in;
    logic [31:0] val_rm_in;
    logic        ready;
    logic [31:0] mem_rdata_out;

    // Pipeline (EXE/MEM register side) issues requests and watches ready.
    modport master (
        output mem_r_en_in, mem_w_en_in, ALU_result_in, val_rm_in,
        input  ready, mem_rdata_out
    );

    // Controller consumes requests and reports ready / load data.
    modport slave (
        input  mem_r_en_in, mem_w_en_in, ALU_result_in, val_rm_in,
        output ready, mem_rdata_out
    );

endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM-stage controller splitting 32-bit accesses into two SRAM half-word accesses
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 2,
    parameter int unsigned MEM_BASE     = DEF_MEM_BASE,
    parameter int unsigned SRAM_AW      = DEF_SRAM_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_stage_sram_ctrl_if.slave bus,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);

    // Word index occupies all SRAM address bits except the half-word select.
    localparam int         WIDX     = SRAM_AW - 1;
    localparam logic [3:0] CNT_LAST = 4'(PHASE_CYCLES - 1);

    mem_state_t         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               op_wr_q, op_wr_d;
    logic [SRAM_AW-1:0] addr_hold_q;

    logic               ready;
    logic               in_phase;
    logic               phase_end;
    logic               dq_oe;
    logic [WIDX-1:0]    word_idx;
    logic [SRAM_AW-1:0] phase_addr;
    logic [SRAM_DW-1:0] dq_out;

    // Pin-facing signals come only from registered state and latched request fields.
    assign in_phase   = (state_q == ST_LO) || (state_q == ST_HI);
    assign phase_end  = in_phase && (cnt_q == CNT_LAST);
    assign word_idx   = WIDX'((addr_q - 32'(MEM_BASE)) >> 2);
    assign phase_addr = {word_idx, (state_q == ST_HI)};
    assign dq_oe      = in_phase && op_wr_q;
    assign dq_out     = (state_q == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];

    assign SRAM_DQ    = dq_oe ? dq_out : {SRAM_DW{1'bz}};
    assign SRAM_WE_N  = ~dq_oe;
    assign SRAM_ADDR  = in_phase ? phase_addr : addr_hold_q;
    assign SRAM_CE_N  = 1'b0;
    assign SRAM_OE_N  = 1'b0;
    assign SRAM_UB_N  = 1'b0;
    assign SRAM_LB_N  = 1'b0;

    assign bus.ready         = ready;
    assign bus.mem_rdata_out = rdata_q;

    // Next-state, phase counter, request latch and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        rdata_d = rdata_q;
        ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = ~(bus.mem_r_en_in | bus.mem_w_en_in);
                if (bus.mem_r_en_in || bus.mem_w_en_in) begin
                    addr_d  = bus.ALU_result_in;
                    wdata_d = bus.val_rm_in;
                    // A store wins when both enables are raised together.
                    op_wr_d = bus.mem_w_en_in;
                    cnt_d   = 4'd0;
                    state_d = ST_LO;
                end
            end
            ST_LO, ST_HI: begin
                if (phase_end) begin
                    cnt_d = 4'd0;
                    if (state_q == ST_LO) begin
                        state_d = ST_HI;
                        if (!op_wr_q) begin
                            rdata_d[15:0] = SRAM_DQ;
                        end
                    end else begin
                        state_d = ST_DONE;
                        if (!op_wr_q) begin
                            rdata_d[31:16] = SRAM_DQ;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                // Pipeline advances on this edge, so the request is not seen again.
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset may land mid-access and abandons it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            op_wr_q     <= 1'b0;
            rdata_q     <= 32'd0;
            addr_hold_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
            if (in_phase) begin
                addr_hold_q <= phase_addr;
            end
        end
    end

endmodule
